// File: rtl/dsp_mac_sequencer.sv
// Control sequencer that drives a DSP48A1 slice through an N_TAPS-long unsigned multiply-accumulate.
// Optional rounding (C-port bias plus right shift of P) is enabled by defining MAC_ROUND_EN.
module dsp_mac_sequencer #(
    parameter int N_TAPS      = 8,
    parameter int DSP_LATENCY = 3,
    parameter int CTRL_DELAY  = 1,
    parameter int RND_SHIFT   = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [17:0] in_a_i,
    input  logic [17:0] in_b_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [47:0] result_o,
    output logic        busy_o,
    output logic [17:0] dsp_a_o,
    output logic [17:0] dsp_b_o,
    output logic [47:0] dsp_c_o,
    output logic [7:0]  dsp_opmode_o,
    output logic        dsp_ce_o,
    input  logic [47:0] dsp_p_i
);

`ifdef MAC_ROUND_EN
    localparam bit ROUND_EN = 1'b1;
`else
    localparam bit ROUND_EN = 1'b0;
`endif

    localparam int CNT_W = $clog2(N_TAPS + 1);
    localparam int DRN_W = (DSP_LATENCY > 1) ? $clog2(DSP_LATENCY + 1) : 1;
    localparam logic [47:0] RND_HALF = 48'd1 << (RND_SHIFT - 1);

    localparam logic [7:0] OP_CLEAR = 8'h01;
    localparam logic [7:0] OP_ACC   = 8'h09;
    localparam logic [7:0] OP_BIAS  = 8'h0D;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DRN_W-1:0]   drain_q, drain_d;
    logic               first_seen_q, first_seen_d;
    logic               ce_ext_q;
    logic [47:0]        result_q, result_d;

    logic               fire;
    logic [7:0]         slot_op;
    logic [47:0]        slot_c;

    logic [7:0]         op_pipe_q [CTRL_DELAY];
    logic [47:0]        c_pipe_q  [CTRL_DELAY];

    assign fire = in_valid_i && in_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            drain_q      <= '0;
            first_seen_q <= 1'b0;
            ce_ext_q     <= 1'b0;
            result_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            drain_q      <= drain_d;
            first_seen_q <= first_seen_d;
            ce_ext_q     <= (state_q == DRAIN);
            result_q     <= result_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        drain_d      = drain_q;
        first_seen_d = first_seen_q;
        result_d     = result_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d      = ACCUM;
                    cnt_d        = '0;
                    drain_d      = '0;
                    first_seen_d = 1'b0;
                end
            end
            ACCUM: begin
                if (fire) begin
                    cnt_d        = cnt_q + 1'b1;
                    first_seen_d = 1'b1;
                    if (cnt_q == CNT_W'(N_TAPS - 1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                drain_d = drain_q + 1'b1;
                if (drain_q == DRN_W'(DSP_LATENCY - 1)) begin
                    // P now includes the last accepted slot
                    result_d = ROUND_EN ? (dsp_p_i >> RND_SHIFT) : dsp_p_i;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready_o  = (state_q == ACCUM) && (cnt_q < CNT_W'(N_TAPS));
        busy_o      = (state_q != IDLE);
        out_valid_o = (state_q == DONE);
        result_o    = result_q;
        dsp_ce_o    = (state_q == ACCUM) || (state_q == DRAIN) ||
                      ((state_q == DONE) && ce_ext_q);
        dsp_a_o     = '0;
        dsp_b_o     = '0;
        slot_op     = 8'h00;
        slot_c      = '0;
        case (state_q)
            ACCUM: begin
                if (fire) begin
                    dsp_a_o = in_a_i;
                    dsp_b_o = in_b_i;
                end
                // Slots up to and including the first pair overwrite P instead of adding to it
                if (first_seen_q) begin
                    slot_op = OP_ACC;
                end else if (fire && ROUND_EN) begin
                    slot_op = OP_BIAS;
                    slot_c  = RND_HALF;
                end else begin
                    slot_op = OP_CLEAR;
                end
            end
            DRAIN:   slot_op = OP_ACC;
            default: slot_op = 8'h00;
        endcase
        dsp_opmode_o = op_pipe_q[CTRL_DELAY-1];
        dsp_c_o      = c_pipe_q[CTRL_DELAY-1];
    end

    generate
        for (genvar gi = 0; gi < CTRL_DELAY; gi++) begin : g_ctrl_pipe
            if (gi == 0) begin : g_head
                always_ff @(posedge clk_i) begin
                    if (rst_i) begin
                        op_pipe_q[gi] <= '0;
                        c_pipe_q[gi]  <= '0;
                    end else begin
                        op_pipe_q[gi] <= slot_op;
                        c_pipe_q[gi]  <= slot_c;
                    end
                end
            end else begin : g_tail
                always_ff @(posedge clk_i) begin
                    if (rst_i) begin
                        op_pipe_q[gi] <= '0;
                        c_pipe_q[gi]  <= '0;
                    end else begin
                        op_pipe_q[gi] <= op_pipe_q[gi-1];
                        c_pipe_q[gi]  <= c_pipe_q[gi-1];
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Scoreboard bench for dsp_mac_sequencer with a behavioural DSP48A1 slice closing the P loop.
// Expected results come from plain dot-product arithmetic; rounding follows MAC_ROUND_EN.
module tb_dsp_mac_sequencer;

    localparam int NT  = 4;
    localparam int LAT = 3;
    localparam int RND = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [17:0] in_a = '0;
    logic [17:0] in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [47:0] result;
    logic        busy;
    logic [17:0] dsp_a, dsp_b;
    logic [47:0] dsp_c;
    logic [7:0]  dsp_opmode;
    logic        dsp_ce;
    logic [47:0] dsp_p;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_results = 0;

    logic [47:0] exp_q [$];
    logic [17:0] pa [$];
    logic [17:0] pb [$];
    int          bub [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dsp_mac_sequencer #(
        .N_TAPS(NT), .DSP_LATENCY(LAT), .CTRL_DELAY(1), .RND_SHIFT(RND)
    ) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_a_i(in_a), .in_b_i(in_b),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .result_o(result), .busy_o(busy),
        .dsp_a_o(dsp_a), .dsp_b_o(dsp_b), .dsp_c_o(dsp_c),
        .dsp_opmode_o(dsp_opmode), .dsp_ce_o(dsp_ce), .dsp_p_i(dsp_p)
    );

    // DSP48A1 with A1REG=B1REG=CREG=MREG=PREG=OPMODEREG=1; not reset, so stale state must be flushed by the sequencer
    logic [17:0] s_a1 = '0, s_b1 = '0;
    logic [35:0] s_m = '0;
    logic [7:0]  s_op = '0;
    logic [47:0] s_c = '0, s_p = '0;
    logic [47:0] s_x, s_z;

    always_comb begin
        s_x = '0;
        s_z = '0;
        case (s_op[1:0])
            2'b01:   s_x = {12'd0, s_m};
            2'b10:   s_x = s_p;
            default: s_x = '0;
        endcase
        case (s_op[3:2])
            2'b10:   s_z = s_p;
            2'b11:   s_z = s_c;
            default: s_z = '0;
        endcase
    end

    always @(posedge clk) begin
        if (dsp_ce) begin
            s_a1 <= dsp_a;
            s_b1 <= dsp_b;
            s_m  <= s_a1 * s_b1;
            s_op <= dsp_opmode;
            s_c  <= dsp_c;
            s_p  <= s_op[7] ? (s_z - (s_x + 48'(s_op[5]))) : (s_z + s_x + 48'(s_op[5]));
        end
    end
    assign dsp_p = s_p;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [47:0] ref_dot();
        logic [47:0] s = '0;
        foreach (pa[i]) s = s + 48'(pa[i]) * 48'(pb[i]);
`ifdef MAC_ROUND_EN
        s = (s + (48'd1 << (RND - 1))) >> RND;
`endif
        return s;
    endfunction

    // Monitor: pops the scoreboard on every output handshake and checks RESULT stays put while stalled
    logic        prev_valid = 1'b0;
    logic        prev_hs = 1'b0;
    logic [47:0] prev_result = '0;
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                if (prev_valid && !prev_hs) chk("result_stable", 64'(result), 64'(prev_result));
                if (out_ready) begin
                    n_results++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_result", 64'(result), 64'hDEAD);
                    end else begin
                        logic [47:0] e;
                        e = exp_q.pop_front();
                        $display("result %0d: got 0x%0h expected 0x%0h", n_results, result, e);
                        chk("result", 64'(result), 64'(e));
                    end
                end
            end
            prev_valid  = out_valid;
            prev_hs     = out_valid && out_ready;
            prev_result = result;
        end
    end

    task automatic run_dot(input int hold, input bit check_lat, input int exp_lat);
        int t0;
        int n;
        exp_q.push_back(ref_dot());
        start = 1'b1;
        t0 = cyc;
        tick();
        start = 1'b0;
        chk("start_accept", 64'(busy), 64'd1);
        foreach (pa[i]) begin
            repeat (bub[i]) begin
                in_valid = 1'b0;
                tick();
            end
            in_valid = 1'b1;
            in_a = pa[i];
            in_b = pb[i];
            n = 0;
            while (!in_ready && n < 50) begin
                tick();
                n++;
            end
            if (n >= 50) chk("in_ready_timeout", 64'(in_ready), 64'd1);
            tick();
        end
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        n = 0;
        while (!out_valid && n < 200) begin
            tick();
            n++;
        end
        chk("done_timeout", 64'(out_valid), 64'd1);
        if (check_lat) chk("latency", 64'(cyc - t0), 64'(exp_lat));
        for (int h = 0; h < hold; h++) begin
            if (h == 1) begin
                start = 1'b1;
                tick();
                start = 1'b0;
                chk("start_in_done_busy", 64'(busy), 64'd1);
                chk("start_in_done_valid", 64'(out_valid), 64'd1);
            end else begin
                tick();
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("valid_drop", 64'(out_valid), 64'd0);
    endtask

    task automatic load_pairs(input logic [17:0] a, input logic [17:0] b, input int nb);
        pa.delete(); pb.delete(); bub.delete();
        for (int i = 0; i < NT; i++) begin
            pa.push_back(a + 18'(i * 2 * (a == 18'd1 ? 1 : 0)));
            pb.push_back(b + 18'(i * 2 * (a == 18'd1 ? 1 : 0)));
            bub.push_back(nb);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ce", 64'(dsp_ce), 64'd0);
        chk("rst_dsp_ab", 64'({dsp_a, dsp_b}), 64'd0);
        chk("rst_dsp_c_op", 64'({dsp_c, dsp_opmode}), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        rst = 1'b0;
        tick();

        // (1,2),(3,4),(5,6),(7,8) back to back, then with a bubble before each pair
        load_pairs(18'd1, 18'd2, 0);
        run_dot(0, 1'b1, NT + LAT + 1);
        load_pairs(18'd1, 18'd2, 1);
        run_dot(0, 1'b1, NT + LAT + 1 + NT);
        tick();

        // Stall in DONE with a stray START
        load_pairs(18'd1, 18'd2, 0);
        run_dot(5, 1'b1, NT + LAT + 1);
        chk("idle_after_hs", 64'(busy), 64'd0);
        tick();

        // Abort mid-ACCUM after two pairs
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_a = 18'd1000 + 18'(i);
            in_b = 18'd3000;
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_ce", 64'(dsp_ce), 64'd0);
        chk("abort_dsp", 64'({dsp_a, dsp_b, dsp_opmode}), 64'd0);
        repeat (3) tick();
        chk("abort_no_valid", 64'(out_valid), 64'd0);
        load_pairs(18'd10, 18'd10, 0);
        run_dot(0, 1'b1, NT + LAT + 1);
        tick();

        // Rounding case
        load_pairs(18'd100, 18'd1, 0);
        run_dot(0, 1'b1, NT + LAT + 1);

        // Full-scale operands, second START right after the handshake
        load_pairs(18'h3FFFF, 18'h3FFFF, 0);
        run_dot(0, 1'b1, NT + LAT + 1);
        run_dot(0, 1'b1, NT + LAT + 1);

        // Random operands, bubbles and stalls
        for (int r = 0; r < 8; r++) begin
            pa.delete(); pb.delete(); bub.delete();
            for (int i = 0; i < NT; i++) begin
                pa.push_back(18'($urandom));
                pb.push_back(18'($urandom));
                bub.push_back(int'($urandom_range(0, 2)));
            end
            run_dot(int'($urandom_range(0, 3)), 1'b0, 0);
            repeat ($urandom_range(0, 2)) tick();
        end

        repeat (4) tick();
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dsp_mac_sequencer.md
# dsp_mac_sequencer

- Upstream control stage for the DSP48A1 slice.
- Accepts a stream of 18-bit operand pairs over a valid/ready handshake and drives the slice's A, B, C and OPMODE inputs so it computes an N_TAPS-long unsigned multiply-accumulate.
- Waits out the slice pipeline, captures P and presents the 48-bit dot product on an output valid/ready handshake.
- Slice parameters it is timed for: A0REG=0, A1REG=1, B0REG=0, B1REG=1, CREG=1, MREG=1, PREG=1, OPMODEREG=1, B_INPUT="DIRECT", CARRYINSEL="OPMODE5".

## Interface
- N_TAPS, 8: operand pairs per dot product; range 1..1023.
- DSP_LATENCY, 3: cycles from an operand slot on DSP_A/DSP_B to its accumulated value on DSP_P.
- CTRL_DELAY, 1: register stages on DSP_OPMODE/DSP_C relative to operands (matches OPMODEREG/CREG); at least 1.
- RND_SHIFT, 8: rounding bit position; used only with the macro; range 1..47.
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  one-cycle request to begin a dot product; honoured only in IDLE.
- IN_VALID  in  1  operand pair valid.
- IN_READY  out  1  sequencer accepts a pair this cycle.
- IN_A, IN_B  in  18 each  unsigned operands.
- OUT_VALID  out  1  RESULT valid.
- OUT_READY  in  1  consumer takes RESULT.
- RESULT  out  48  dot product.
- BUSY  out  1  high in every state except IDLE.
- DSP_A, DSP_B  out  18 each  slice A/B inputs.
- DSP_C  out  48  slice C input.
- DSP_OPMODE  out  8  slice OPMODE input.
- DSP_CE  out  1  clock enable for all slice CE inputs.
- DSP_P  in  48  slice P output.

## Operation
- **States:** IDLE, ACCUM, DRAIN, DONE.
- **IDLE:** START moves to ACCUM; slot counter and drain counter cleared. START in any other state is ignored.
- **ACCUM:** IN_READY = (accepted < N_TAPS). Each cycle is one slot.
  - Fire (IN_VALID & IN_READY): DSP_A=IN_A, DSP_B=IN_B, accepted count increments.
  - No fire: DSP_A=DSP_B=0 (bubble).
- **Slot OPMODE:** 8'h01 (X=M, Z=0, add, no carry) for every slot until the first pair is accepted, including that pair's slot; 8'h09 (X=M, Z=P) afterwards.
  - Bubbles therefore add zero; the pre-adder is never used (bit 4 = 0).
- **Control delay:** slot OPMODE and slot C value pass through a CTRL_DELAY-deep register pipe before reaching DSP_OPMODE/DSP_C.
- **ACCUM → DRAIN:** on the cycle after the N_TAPS-th fire. DRAIN slots drive A=B=0 with OPMODE 8'h09.
- **DRAIN:** lasts DSP_LATENCY cycles. On the last one, RESULT is loaded from DSP_P and the state moves to DONE.
- **DONE:** OUT_VALID=1; RESULT held stable. OUT_READY returns to IDLE on the same edge.
- **DSP_CE:** 1 in ACCUM and DRAIN, and one further cycle after entering DONE; 0 otherwise, so the slice holds P while idle.
- **Arithmetic:** unsigned, modulo 2^48; no overflow flag.
- **Reset:** RST at any time, including mid-ACCUM or mid-DRAIN, forces IDLE and aborts the dot product.
  - All outputs and the control pipe reset to 0: IN_READY, OUT_VALID, BUSY, DSP_CE, DSP_A, DSP_B, DSP_C, DSP_OPMODE, RESULT.
  - A partially accumulated result is discarded; the next START re-clears P via OPMODE 8'h01.

## Timing
- Slot t operands reach the slice at t. OPMODE/C for slot t appear at t+CTRL_DELAY.
- P including slot t is valid at t+DSP_LATENCY.
- Last fire at cycle L → DRAIN cycles L+1..L+DSP_LATENCY → RESULT/OUT_VALID visible at L+DSP_LATENCY+1.
- Minimum START-to-OUT_VALID: N_TAPS+DSP_LATENCY+1 cycles with IN_VALID held high.
- IN_READY combinational on state/count only; never depends on IN_VALID.
- OUT_VALID deasserts the cycle after the OUT_READY handshake; a new START is accepted that cycle at the earliest.

## Configuration
- **MAC_ROUND_EN defined:**
  - First-pair slot uses OPMODE 8'h0D (Z=C), with slot C value 1<<(RND_SHIFT-1); C is 0 in all other slots.
  - RESULT = captured P logically shifted right by RND_SHIFT (round-half-up).
- **MAC_ROUND_EN undefined:** DSP_C tied to 0, OPMODE as above, RESULT = captured P unshifted.

## Test plan
- N_TAPS=4, IN_VALID always high, pairs (1,2),(3,4),(5,6),(7,8), no macro → RESULT=100, OUT_VALID exactly 8 cycles after START.
- Same pairs with one bubble cycle before each pair → RESULT=100; OUT_VALID 4 cycles later than the previous case.
- OUT_READY held low 5 cycles in DONE → RESULT and OUT_VALID stable throughout; START pulsed during DONE ignored; BUSY stays 1.
- RST asserted mid-ACCUM after 2 pairs, then new START with 4×(10,10) → RESULT=400; no residue from the aborted run.
- MAC_ROUND_EN, RND_SHIFT=8, 4×(100,1) → RESULT=2; without the macro → RESULT=400.
- Back-to-back: two dot products of 4×(0x3FFFF,0x3FFFF) → each RESULT=0x3_FFFE_0000_4; second START accepted the cycle after the OUT_READY handshake.
